noc_packet_sink: RTL and testbench

NOC_PACKET_SINK -- requirements
Module: noc_packet_sink

---
 rtl/noc_packet_sink.sv | 209 ++++++++++++++++++++
 tb/tb_noc_packet_sink.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_packet_sink.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | noc_packet_sink: buffers incoming NoC flits, parses packets, reports        |
// | per-packet results and keeps clean/errored statistics.                      |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+

`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif
`ifndef Noc_ID_X_Width
`define Noc_ID_X_Width 2
`endif
`ifndef Noc_ID_Y_Width
`define Noc_ID_Y_Width 2
`endif
`ifndef Noc_Point_H
`define Noc_Point_H 32
`endif
`ifndef Noc_Source_Point
`define Noc_Source_Point 28
`endif

module noc_packet_sink #(
  parameter logic [`Noc_ID_X_Width-1:0] X_ID           = '0,
  parameter logic [`Noc_ID_Y_Width-1:0] Y_ID           = '0,
  parameter int                         EXP_DATA_FLITS = 10,
  parameter int                         FIFO_DEPTH     = 4
) (
  input  logic                       noc_clk,
  input  logic                       noc_rst_n,
  input  logic                       receive_valid,
  output logic                       receive_ready,
  input  logic [`Noc_Data_Width-1:0] receive_flit,
  input  logic                       receive_is_header,
  input  logic                       receive_is_tail,
  input  logic                       sink_stall,
  input  logic                       clear,
  output logic                       pkt_done,
  output logic [`Noc_ID_X_Width-1:0] pkt_src_x,
  output logic [`Noc_ID_Y_Width-1:0] pkt_src_y,
  output logic [7:0]                 pkt_len,
  output logic [3:0]                 pkt_err,
  output logic                       flit_drop,
  output logic [15:0]                ok_count,
  output logic [15:0]                err_count
);

  localparam int            c_DW      = `Noc_Data_Width;
  localparam int            c_YW      = `Noc_ID_Y_Width;
  localparam int            c_IDW     = `Noc_ID_X_Width + `Noc_ID_Y_Width;
  localparam int            c_AW      = $clog2(FIFO_DEPTH);
  localparam int            c_EW      = c_DW + 2;
  localparam logic [7:0]    c_EXP_LEN = 8'(EXP_DATA_FLITS);
  localparam logic [c_AW:0] c_DEPTH   = (c_AW + 1)'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_PAYLOAD = 1'b1
  } state_t;

  logic [c_EW-1:0]  r_mem [FIFO_DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_AW:0]    r_count;
  logic             w_push;
  logic             w_pop;
  logic             w_hd_hdr;
  logic             w_hd_tail;
  logic [c_IDW-1:0] w_src;
  logic [c_IDW-1:0] w_dst;
  logic             w_dest_bad;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [c_IDW-1:0] r_src;
  logic [c_IDW-1:0] w_src_nxt;
  logic             r_dest_err;
  logic             w_dest_err_nxt;
  logic [7:0]       r_len;
  logic [7:0]       w_len_nxt;
  logic             w_finish;
  logic             w_drop;
  logic [c_IDW-1:0] w_fin_src;
  logic [7:0]       w_fin_len;
  logic [3:0]       w_fin_err;
  logic             w_fin_clean;
  logic             w_fin_bad;

  // Full FIFO never accepts, even when the head is popped in the same cycle.
  assign receive_ready = (r_count < c_DEPTH);
  assign w_push        = receive_valid & receive_ready;
  assign w_pop         = (r_count != '0) & ~sink_stall;

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (c_AW + 1)'(1);
        2'b01:   r_count <= r_count - (c_AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge noc_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {receive_is_header, receive_is_tail, receive_flit};
  end

  assign w_hd_hdr   = r_mem[r_rd_ptr][c_EW-1];
  assign w_hd_tail  = r_mem[r_rd_ptr][c_EW-2];
  assign w_src      = r_mem[r_rd_ptr][`Noc_Point_H-1:`Noc_Source_Point];
  assign w_dst      = r_mem[r_rd_ptr][`Noc_Source_Point-1 -: c_IDW];
  assign w_dest_bad = (w_dst != {X_ID, Y_ID});

  always_comb begin
    w_state_nxt    = r_state;
    w_src_nxt      = r_src;
    w_dest_err_nxt = r_dest_err;
    w_len_nxt      = r_len;
    w_finish       = 1'b0;
    w_drop         = 1'b0;
    w_fin_src      = r_src;
    w_fin_len      = r_len;
    w_fin_err      = 4'b0000;
    if (w_pop) begin
      case (r_state)
        S_IDLE: begin
          if (w_hd_hdr) begin
            w_src_nxt      = w_src;
            w_dest_err_nxt = w_dest_bad;
            w_len_nxt      = '0;
            if (w_hd_tail) begin
              // Single-flit packet: header and tail checks collapse into one edge.
              w_finish  = 1'b1;
              w_fin_src = w_src;
              w_fin_len = '0;
              w_fin_err = {2'b00, (c_EXP_LEN != 8'd0), w_dest_bad};
            end else begin
              w_state_nxt = S_PAYLOAD;
            end
          end else begin
            w_drop = 1'b1;
          end
        end
        S_PAYLOAD: begin
          if (w_hd_hdr) begin
            w_finish       = 1'b1;
            w_fin_err      = {1'b1, 2'b00, r_dest_err};
            w_src_nxt      = w_src;
            w_dest_err_nxt = w_dest_bad;
            w_len_nxt      = '0;
          end else if (w_hd_tail) begin
            w_finish    = 1'b1;
            w_fin_err   = {1'b0, (w_src != r_src), (r_len != c_EXP_LEN), r_dest_err};
            w_state_nxt = S_IDLE;
          end else if (r_len != 8'hFF) begin
            w_len_nxt = r_len + 8'd1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign w_fin_clean = w_finish & (w_fin_err == 4'b0000);
  assign w_fin_bad   = (w_finish & (w_fin_err != 4'b0000)) | w_drop;

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      r_state    <= S_IDLE;
      r_src      <= '0;
      r_dest_err <= 1'b0;
      r_len      <= '0;
      pkt_done   <= 1'b0;
      flit_drop  <= 1'b0;
      pkt_src_x  <= '0;
      pkt_src_y  <= '0;
      pkt_len    <= '0;
      pkt_err    <= '0;
      ok_count   <= '0;
      err_count  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_src      <= w_src_nxt;
      r_dest_err <= w_dest_err_nxt;
      r_len      <= w_len_nxt;
      pkt_done   <= w_finish;
      flit_drop  <= w_drop;
      if (w_finish) begin
        pkt_src_x <= w_fin_src[c_IDW-1:c_YW];
        pkt_src_y <= w_fin_src[c_YW-1:0];
        pkt_len   <= w_fin_len;
        pkt_err   <= w_fin_err;
      end
      if (clear)                                  ok_count <= '0;
      else if (w_fin_clean && ok_count != 16'hFFFF) ok_count <= ok_count + 16'd1;
      if (clear)                                  err_count <= '0;
      else if (w_fin_bad && err_count != 16'hFFFF)  err_count <= err_count + 16'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_noc_packet_sink.sv
`default_nettype none
// Bench for noc_packet_sink: directed scenarios plus randomized packet traffic
// checked against a packet-level scoreboard.
module tb_noc_packet_sink;

  localparam logic [1:0] LX  = 2'd1;
  localparam logic [1:0] LY  = 2'd2;
  localparam int         EXP = 10;

  logic        noc_clk = 1'b0;
  logic        noc_rst_n = 1'b0;
  logic        receive_valid = 1'b0;
  logic        receive_ready;
  logic [31:0] receive_flit = '0;
  logic        receive_is_header = 1'b0;
  logic        receive_is_tail = 1'b0;
  logic        sink_stall = 1'b0;
  logic        clear = 1'b0;
  logic        pkt_done;
  logic [1:0]  pkt_src_x;
  logic [1:0]  pkt_src_y;
  logic [7:0]  pkt_len;
  logic [3:0]  pkt_err;
  logic        flit_drop;
  logic [15:0] ok_count;
  logic [15:0] err_count;

  noc_packet_sink #(
    .X_ID(LX), .Y_ID(LY), .EXP_DATA_FLITS(EXP), .FIFO_DEPTH(4)
  ) dut (
    .noc_clk(noc_clk), .noc_rst_n(noc_rst_n),
    .receive_valid(receive_valid), .receive_ready(receive_ready),
    .receive_flit(receive_flit), .receive_is_header(receive_is_header),
    .receive_is_tail(receive_is_tail), .sink_stall(sink_stall), .clear(clear),
    .pkt_done(pkt_done), .pkt_src_x(pkt_src_x), .pkt_src_y(pkt_src_y),
    .pkt_len(pkt_len), .pkt_err(pkt_err), .flit_drop(flit_drop),
    .ok_count(ok_count), .err_count(err_count)
  );

  always #5 noc_clk = ~noc_clk;

  typedef struct {
    logic [1:0] sx;
    logic [1:0] sy;
    logic [7:0] len;
    logic [3:0] err;
    logic [3:0] mask;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   exp_ok = 0;
  int   exp_err = 0;
  int   exp_drop = 0;
  int   seen_drop = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] mk(input logic [1:0] sx, sy, dx, dy);
    return {sx, sy, dx, dy, 24'($urandom)};
  endfunction

  // Expected packet result derived from what the sender put on the wire.
  task automatic expect_pkt(input logic [1:0] sx, sy, dx, dy, input int n,
                            input bit tail_on, input logic [1:0] tsx, tsy, input bit single);
    exp_t e;
    logic dbad;
    dbad   = ({dx, dy} != {LX, LY});
    e.sx   = sx;
    e.sy   = sy;
    e.mask = 4'hF;
    if (single) begin
      e.len = 8'd0;
      e.err = {2'b00, (EXP != 0), dbad};
    end else begin
      e.len = (n > 255) ? 8'hFF : 8'(n);
      if (tail_on) begin
        e.err = {1'b0, ({tsx, tsy} != {sx, sy}), (n != EXP), dbad};
      end else begin
        e.err  = {1'b1, 2'b00, dbad};
        e.mask = 4'b1001;
      end
    end
    exp_q.push_back(e);
    if (e.err != 4'b0000) exp_err++;
    else exp_ok++;
  endtask

  task automatic idle();
    receive_valid     = 1'b0;
    receive_is_header = 1'b0;
    receive_is_tail   = 1'b0;
  endtask

  // Entered at a falling edge; returns at the falling edge after the accepting edge.
  task automatic send_flit(input logic [31:0] f, input logic h, input logic t);
    int g;
    g = 0;
    receive_valid     = 1'b1;
    receive_flit      = f;
    receive_is_header = h;
    receive_is_tail   = t;
    while (receive_ready !== 1'b1 && g < 200) begin
      @(negedge noc_clk);
      g++;
      if (g > 2) sink_stall = 1'b0;
    end
    if (g >= 200) check("ready_timeout", 32'd0, 32'd1);
    @(negedge noc_clk);
  endtask

  task automatic flit_gap(input bit rnd);
    if (rnd) begin
      sink_stall = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 4) == 0) begin
        idle();
        @(negedge noc_clk);
      end
    end
  endtask

  task automatic send_packet(input logic [1:0] sx, sy, dx, dy, input int n, input bit tail_on,
                             input logic [1:0] tsx, tsy, input bit single, input bit rnd);
    expect_pkt(sx, sy, dx, dy, n, tail_on, tsx, tsy, single);
    flit_gap(rnd);
    send_flit(mk(sx, sy, dx, dy), 1'b1, single);
    if (!single) begin
      for (int i = 0; i < n; i++) begin
        flit_gap(rnd);
        send_flit(32'($urandom), 1'b0, 1'b0);
      end
      if (tail_on) begin
        flit_gap(rnd);
        send_flit(mk(tsx, tsy, 2'($urandom), 2'($urandom)), 1'b0, 1'b1);
      end
    end
    idle();
    sink_stall = 1'b0;
  endtask

  task automatic drain_check(input string tag);
    idle();
    sink_stall = 1'b0;
    repeat (30) @(negedge noc_clk);
    check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_drops"}, 32'(seen_drop), 32'(exp_drop));
    check({tag, "_ok_count"}, 32'(ok_count), 32'(exp_ok));
    check({tag, "_err_count"}, 32'(err_count), 32'(exp_err));
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge noc_clk);
    clear   = 1'b0;
    exp_ok  = 0;
    exp_err = 0;
    check("clear_ok", 32'(ok_count), 32'd0);
    check("clear_err", 32'(err_count), 32'd0);
  endtask

  always @(negedge noc_clk) begin
    if (noc_rst_n === 1'b1) begin
      if (pkt_done === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pkt_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("pkt_src_x", 32'(pkt_src_x), 32'(e.sx));
          check("pkt_src_y", 32'(pkt_src_y), 32'(e.sy));
          check("pkt_len", 32'(pkt_len), 32'(e.len));
          check("pkt_err", 32'(pkt_err & e.mask), 32'(e.err & e.mask));
        end
      end
      if (flit_drop === 1'b1) seen_drop++;
    end
  end

  initial begin
    #1;
    check("rst_ready", 32'(receive_ready), 32'd1);
    check("rst_done", 32'(pkt_done), 32'd0);
    check("rst_drop", 32'(flit_drop), 32'd0);
    check("rst_len", 32'(pkt_len), 32'd0);
    check("rst_err", 32'(pkt_err), 32'd0);
    check("rst_ok_count", 32'(ok_count), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    repeat (3) @(negedge noc_clk);
    noc_rst_n = 1'b1;
    @(negedge noc_clk);

    // Clean packet
    send_packet(2'd0, 2'd0, LX, LY, 10, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0);
    drain_check("basic");
    check("basic_hold_err", 32'(pkt_err), 32'd0);
    check("basic_hold_len", 32'(pkt_len), 32'd10);
    do_clear();

    // Short packet to wrong destination
    send_packet(2'd0, 2'd0, 2'd3, 2'd3, 9, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0);
    drain_check("len_dest");
    check("len_dest_err", 32'(pkt_err), 32'h3);
    check("len_dest_len", 32'(pkt_len), 32'd9);
    do_clear();

    // Truncated packet followed by a complete one
    send_packet(2'd0, 2'd0, LX, LY, 3, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
    send_packet(2'd0, 2'd0, LX, LY, 10, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0);
    drain_check("trunc");
    do_clear();

    // Orphan data flit while idle
    send_flit(32'($urandom), 1'b0, 1'b0);
    idle();
    exp_drop++;
    exp_err++;
    drain_check("orphan");
    do_clear();

    // Backpressure: four flits fill the stalled FIFO, the fifth waits
    expect_pkt(2'd1, 2'd3, LX, LY, 10, 1'b1, 2'd1, 2'd3, 1'b0);
    sink_stall = 1'b1;
    send_flit(mk(2'd1, 2'd3, LX, LY), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) send_flit(32'($urandom), 1'b0, 1'b0);
    check("stall_full_ready", 32'(receive_ready), 32'd0);
    receive_flit      = 32'($urandom);
    receive_is_header = 1'b0;
    receive_is_tail   = 1'b0;
    receive_valid     = 1'b1;
    repeat (3) begin
      @(negedge noc_clk);
      check("stall_held_ready", 32'(receive_ready), 32'd0);
    end
    sink_stall = 1'b0;
    send_flit(receive_flit, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) send_flit(32'($urandom), 1'b0, 1'b0);
    send_flit(mk(2'd1, 2'd3, 2'd0, 2'd0), 1'b0, 1'b1);
    drain_check("stall");
    check("stall_len", 32'(pkt_len), 32'd10);
    do_clear();

    // Randomized traffic
    begin
      bit         force_norm;
      int         k;
      logic [1:0] sx, sy, dx, dy, tsx, tsy;
      force_norm = 1'b0;
      for (int i = 0; i < 40; i++) begin
        k  = $urandom_range(0, 9);
        sx = 2'($urandom);
        sy = 2'($urandom);
        if ($urandom_range(0, 3) != 0) begin dx = LX; dy = LY; end
        else begin dx = 2'($urandom); dy = 2'($urandom); end
        if ($urandom_range(0, 3) != 0) begin tsx = sx; tsy = sy; end
        else begin tsx = 2'($urandom); tsy = 2'($urandom); end
        if (force_norm || k >= 3 || (k == 2 && i == 39)) begin
          force_norm = 1'b0;
          send_packet(sx, sy, dx, dy, $urandom_range(7, 12), 1'b1, tsx, tsy, 1'b0, 1'b1);
        end else if (k == 0) begin
          flit_gap(1'b1);
          send_flit(32'($urandom), 1'b0, 1'b0);
          idle();
          sink_stall = 1'b0;
          exp_drop++;
          exp_err++;
        end else if (k == 1) begin
          send_packet(sx, sy, dx, dy, 0, 1'b1, sx, sy, 1'b1, 1'b1);
        end else begin
          force_norm = 1'b1;
          send_packet(sx, sy, dx, dy, $urandom_range(0, 6), 1'b0, sx, sy, 1'b0, 1'b1);
        end
      end
    end
    drain_check("random");

    // Reset in the middle of a packet
    send_flit(mk(2'd2, 2'd1, LX, LY), 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) send_flit(32'($urandom), 1'b0, 1'b0);
    idle();
    repeat (5) @(negedge noc_clk);
    noc_rst_n = 1'b0;
    #1;
    check("midrst_ready", 32'(receive_ready), 32'd1);
    check("midrst_done", 32'(pkt_done), 32'd0);
    check("midrst_len", 32'(pkt_len), 32'd0);
    check("midrst_err", 32'(pkt_err), 32'd0);
    check("midrst_src", 32'({pkt_src_x, pkt_src_y}), 32'd0);
    check("midrst_ok_count", 32'(ok_count), 32'd0);
    check("midrst_err_count", 32'(err_count), 32'd0);
    exp_ok  = 0;
    exp_err = 0;
    @(negedge noc_clk);
    @(negedge noc_clk);
    noc_rst_n = 1'b1;
    @(negedge noc_clk);
    send_packet(2'd3, 2'd0, LX, LY, 10, 1'b1, 2'd3, 2'd0, 1'b0, 1'b0);
    drain_check("after_reset");
    check("after_reset_ok", 32'(ok_count), 32'd1);
    do_clear();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
